frame_scanner: RTL and testbench

- Reads the 18x16 RGB frame array produced by the screen-update stage and streams it out pixel-by-pixel to the display driver (LED-chain / serial panel interface).
- Snapshots the whole frame at start of frame so upstream updates never tear a frame mid-scan.
- Row-major scan with valid/ready handshake, start-of-frame/end-of-line markers and an inter-frame blanking gap.

---
 rtl/screen_pkg.sv | 13 +
 rtl/frame_scanner_scan_counter.sv | 66 ++++++
 rtl/frame_scanner.sv | 98 +++++++++
 tb/tb_frame_scanner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared screen types: frame geometry, pixel colour, scanner FSM states.
package screen_pkg;
   localparam int SCREEN_W = 18;
   localparam int SCREEN_H = 16;

   typedef logic [23:0] rgb_t;
   typedef rgb_t [SCREEN_W-1:0][0:SCREEN_H-1] frame_t;

   localparam rgb_t RGB_WHITE = '1;
   localparam rgb_t RGB_BLACK = 24'b0;

   typedef enum logic [1:0] {IDLE, SCAN, BLANK} scan_state_t;
endpackage

// File: rtl/frame_scanner_scan_counter.sv
// Pixel x/y counters with row wrap and sof/eol/last flags.
// SCAN_SERPENTINE_EN: odd rows run right-to-left (zig-zag LED chain).
module scan_counter #(
   parameter int W  = 18,
   parameter int H  = 16,
   parameter int XW = $clog2(W),
   parameter int YW = $clog2(H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          advance,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [XW-1:0] nx,
   output logic [YW-1:0] ny,
   output logic          sof,
   output logic          eol,
   output logic          last
);
   localparam logic [XW-1:0] X_MAX = XW'(W-1);
   localparam logic [YW-1:0] Y_MAX = YW'(H-1);

   logic rev;

`ifdef SCAN_SERPENTINE_EN
   assign rev = y[0];
`else
   assign rev = 1'b0;
`endif

   assign eol  = rev ? (x == '0) : (x == X_MAX);
   assign sof  = (x == '0) && (y == '0);
   assign last = eol && (y == Y_MAX);

   // nx/ny are the coordinates that the next transfer will present
   always_comb begin
      nx = x;
      ny = y;
      if (last) begin
         nx = '0;
         ny = '0;
      end else if (eol) begin
         ny = y + 1'b1;
`ifdef SCAN_SERPENTINE_EN
         nx = ny[0] ? X_MAX : '0;
`else
         nx = '0;
`endif
      end else if (rev) begin
         nx = x - 1'b1;
      end else begin
         nx = x + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         x <= nx;
         y <= ny;
      end
   end
endmodule

// File: rtl/frame_scanner.sv
// Snapshots the frame array and streams it pixel-by-pixel with valid/ready.
// SCAN_SERPENTINE_EN selects zig-zag row order inside scan_counter.
module frame_scanner
   import screen_pkg::*;
#(
   parameter int W         = SCREEN_W,
   parameter int H         = SCREEN_H,
   parameter int BLANK_CYC = 4,
   parameter int XW        = $clog2(W),
   parameter int YW        = $clog2(H)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  rgb_t [W-1:0][0:H-1]        frame,
   input  logic                       px_ready,
   output logic                       px_valid,
   output logic [XW-1:0]              px_x,
   output logic [YW-1:0]              px_y,
   output rgb_t                       px_rgb,
   output logic                       px_sof,
   output logic                       px_eol,
   output logic                       frame_done,
   output logic                       busy
);
   scan_state_t          state, state_nxt;
   rgb_t [W-1:0][0:H-1]  snap;
   logic [7:0]           blank_cnt;
   logic [XW-1:0]        nx;
   logic [YW-1:0]        ny;
   logic                 sof, eol, last;
   logic                 xfer, load;

   assign px_valid = (state == SCAN);
   assign busy     = (state != IDLE);
   assign xfer     = px_valid & px_ready;
   assign px_sof   = px_valid & sof;
   assign px_eol   = px_valid & eol;

   scan_counter #(.W(W), .H(H), .XW(XW), .YW(YW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear   (xfer & last),
      .advance (xfer & ~last),
      .x       (px_x),
      .y       (px_y),
      .nx      (nx),
      .ny      (ny),
      .sof     (sof),
      .eol     (eol),
      .last    (last)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: if (enable) begin
            state_nxt = SCAN;
            load      = 1'b1;
         end
         SCAN: if (xfer && last) state_nxt = BLANK;
         BLANK: if (blank_cnt == '0) begin
            state_nxt = enable ? SCAN : IDLE;
            load      = enable;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         blank_cnt  <= '0;
         frame_done <= 1'b0;
         px_rgb     <= RGB_BLACK;
      end else begin
         frame_done <= xfer & last;
         if (xfer && last)
            blank_cnt <= 8'(BLANK_CYC);
         else if (state == BLANK && blank_cnt != '0)
            blank_cnt <= blank_cnt - 1'b1;
         // first pixel comes straight from the live array, as snap loads on the same edge
         if (load)
            px_rgb <= frame[0][0];
         else if (xfer && !last)
            px_rgb <= snap[nx][ny];
      end
   end

   always_ff @(posedge clk) begin
      if (load) snap <= frame;
   end
endmodule

// File: tb/tb_frame_scanner.sv
// Randomized bench for frame_scanner against a pixel-index reference model.
module tb_frame_scanner;
   import screen_pkg::*;

   localparam int W   = SCREEN_W;
   localparam int H   = SCREEN_H;
   localparam int B   = 4;
   localparam int NPX = W * H;

   logic       clk = 1'b0;
   logic       reset, enable, px_ready;
   frame_t     frame;
   logic       px_valid, px_sof, px_eol, frame_done, busy;
   logic [4:0] px_x;
   logic [3:0] px_y;
   rgb_t       px_rgb;

   frame_scanner #(.W(W), .H(H), .BLANK_CYC(B)) dut (
      .clk(clk), .reset(reset), .enable(enable), .frame(frame), .px_ready(px_ready),
      .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
      .px_sof(px_sof), .px_eol(px_eol), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // model: mode 0 idle, 1 scanning pixel index m_p, 2 blanking
   int     m_mode, m_p, m_blank;
   bit     m_done, m_fresh;
   frame_t m_snap;

   function automatic int col_of(input int p);
      int c;
      c = p % W;
`ifdef SCAN_SERPENTINE_EN
      if (((p / W) % 2) == 1) c = W - 1 - c;
`endif
      return c;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         m_mode = 0; m_p = 0; m_blank = 0; m_done = 0; m_fresh = 1;
      end else begin
         m_done = 0;
         case (m_mode)
            0: if (enable) begin m_snap = frame; m_p = 0; m_mode = 1; m_fresh = 0; end
            1: if (px_ready) begin
               if (m_p == NPX - 1) begin m_done = 1; m_mode = 2; m_blank = B; end
               else m_p++;
            end
            default: begin
               if (m_blank > 0) m_blank--;
               else if (enable) begin m_snap = frame; m_p = 0; m_mode = 1; end
               else m_mode = 0;
            end
         endcase
      end
   end

   int since_done = -1;
   always @(negedge clk) begin
      chk("valid", px_valid, m_mode == 1);
      chk("busy", busy, m_mode != 0);
      chk("frame_done", frame_done, m_done);
      if (m_mode == 1) begin
         chk("px_x", px_x, col_of(m_p));
         chk("px_y", px_y, m_p / W);
         chk("px_rgb", px_rgb, m_snap[col_of(m_p)][m_p / W]);
         chk("px_sof", px_sof, m_p == 0);
         chk("px_eol", px_eol, (m_p % W) == W - 1);
      end else begin
         chk("sof_idle", px_sof, 0);
         chk("eol_idle", px_eol, 0);
         if (m_fresh) begin
            chk("x_rst", px_x, 0);
            chk("y_rst", px_y, 0);
            chk("rgb_rst", px_rgb, 0);
         end
      end
      if (frame_done) since_done = 0;
      else if (!busy) since_done = -1;
      else if (since_done >= 0) since_done++;
      if (px_valid && px_sof && since_done > 0) begin
         chk("sof_gap", since_done, 5);
         since_done = -1;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_pattern();
      for (int x = 0; x < W; x++)
         for (int y = 0; y < H; y++)
            frame[x][y] = {8'(x), 8'(y), 8'hC3};
   endtask

   task automatic set_white();
      for (int x = 0; x < W; x++)
         for (int y = 0; y < H; y++)
            frame[x][y] = RGB_WHITE;
   endtask

   task automatic set_random();
      for (int x = 0; x < W; x++)
         for (int y = 0; y < H; y++)
            frame[x][y] = 24'($urandom);
   endtask

   task automatic wait_p(input int target);
      int n = 0;
      while (!(m_mode == 1 && m_p == target) && n < 3000) begin tick(); n++; end
      if (n >= 3000) begin errors++; $display("FAIL wait_pixel timeout target=%0d", target); end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_done && n < 3000);
      if (n >= 3000) begin errors++; $display("FAIL wait_done timeout"); end
   endtask

   task automatic wait_valid();
      int n = 0;
      do begin @(negedge clk); n++; end while (!px_valid && n < 3000);
      if (n >= 3000) begin errors++; $display("FAIL wait_valid timeout"); end
   endtask

   int n;
   logic [1:0] rdy_pat;

   initial begin
      reset = 1'b0; enable = 1'b0; px_ready = 1'b0;
      set_pattern();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("lit_rst_valid", px_valid, 0);
      chk("lit_rst_busy", busy, 0);
      chk("lit_rst_rgb", px_rgb, 0);

      // first frame, ready always high
      tick(); reset = 1'b1; enable = 1'b1; px_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("lit_first_valid", px_valid, 1);
      chk("lit_first_sof", px_sof, 1);
      chk("lit_first_rgb", px_rgb, 24'h0000C3);
      repeat (17) @(negedge clk);
      chk("lit_p17_eol", px_eol, 1);
      chk("lit_p17_x", px_x, 17);
      @(negedge clk);
`ifdef SCAN_SERPENTINE_EN
      chk("lit_row1_start", px_x, 17);
`else
      chk("lit_row1_start", px_x, 0);
`endif
      chk("lit_row1_y", px_y, 1);
      repeat (17) @(negedge clk);
      chk("lit_row1_eol", px_eol, 1);
`ifdef SCAN_SERPENTINE_EN
      chk("lit_row1_end", px_x, 0);
`else
      chk("lit_row1_end", px_x, 17);
`endif
      @(negedge clk);
      chk("lit_row2_start", px_x, 0);
      repeat (23) @(negedge clk);
`ifdef SCAN_SERPENTINE_EN
      chk("lit_p59_rgb", px_rgb, 24'h0C03C3);
`else
      chk("lit_p59_rgb", px_rgb, 24'h0503C3);
`endif
      wait_done(n);
      chk("lit_done_latency", n, 229);

      // ready 1,0,0,1 stall pattern
      rdy_pat = 2'b00;
      for (int i = 0; i < 400; i++) begin
         tick();
         rdy_pat = 2'(i % 4);
         px_ready = (rdy_pat == 2'd0) || (rdy_pat == 2'd3);
      end
      tick(); px_ready = 1'b1;

      // rewrite to white mid-frame
      wait_p(100);
      set_white();
      wait_done(n);
      wait_valid();
      chk("lit_white_sof", px_sof, 1);
      chk("lit_white_rgb", px_rgb, 24'hFFFFFF);

      // enable dropped mid-frame
      tick(); set_pattern();
      wait_p(50);
      enable = 1'b0;
      wait_done(n);
      repeat (4) @(negedge clk);
      chk("lit_blank_busy", busy, 1);
      @(negedge clk);
      chk("lit_idle_busy", busy, 0);
      chk("lit_idle_valid", px_valid, 0);
      repeat (10) tick();

      // one-cycle reset mid-frame
      enable = 1'b1;
      wait_p(200);
      reset = 1'b0;
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      chk("lit_mrst_valid", px_valid, 0);
      chk("lit_mrst_done", frame_done, 0);
      chk("lit_mrst_busy", busy, 0);
      chk("lit_mrst_x", px_x, 0);
      @(posedge clk); @(negedge clk);
      chk("lit_restart_sof", px_sof, 1);
      chk("lit_restart_xy", {px_x, px_y}, 0);

      // random traffic
      for (int i = 0; i < 5000; i++) begin
         tick();
         px_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 399) == 0) enable = ~enable;
         if ($urandom_range(0, 299) == 0) set_random();
         if ($urandom_range(0, 1999) == 0) begin
            reset = 1'b0; tick(); reset = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
